// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - next-PC selection and IF/ID pipeline register with squash FSM
module if_id_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FLUSH_BUBBLES = 1,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] next_pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        squashing
);

    typedef enum logic {RUN, SQUASH} state_t;

    // Bubbles still owed after the redirect edge itself inserted the first one.
    localparam logic [2:0] RELOAD = 3'(FLUSH_BUBBLES - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [31:0] pc_nx, pc_plus4_nx, instr_nx;
    logic        valid_nx;
    logic [31:0] pc_in_plus4;
    logic        redirect;

    assign pc_in_plus4 = pc_in + 32'd4;
    assign redirect    = jump | branch_taken | flush;
    assign squashing   = (state == SQUASH);

    // Next fetch address: jump beats branch beats stall beats sequential.
    always_comb begin
        next_pc = pc_in_plus4;
        if (jump)
            next_pc = {pc_in_plus4[31:28], jump_target, 2'b00};
        else if (branch_taken)
            next_pc = branch_target;
        else if (stall)
            next_pc = pc_in;
    end

    // Squash FSM and IF/ID register next values: redirect > squash > stall > normal.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pc_nx       = if_id_pc;
        pc_plus4_nx = if_id_pc_plus4;
        instr_nx    = if_id_instr;
        valid_nx    = if_id_valid;
        if (redirect) begin
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
            if (FLUSH_BUBBLES > 1) begin
                state_nx = SQUASH;
                cnt_nx   = RELOAD;
            end else begin
                state_nx = RUN;
                cnt_nx   = 3'd0;
            end
        end else if (state == SQUASH) begin
            instr_nx = NOP_INSTR;
            valid_nx = 1'b0;
            if (!stall) begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1)
                    state_nx = RUN;
            end
        end else if (!stall) begin
            pc_nx       = pc_in;
            pc_plus4_nx = pc_in_plus4;
            instr_nx    = instr_in;
            valid_nx    = 1'b1;
        end
    end

    // State, squash count and IF/ID register, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            cnt            <= 3'd0;
            if_id_pc       <= RESET_PC;
            if_id_pc_plus4 <= RESET_PC + 32'd4;
            if_id_instr    <= NOP_INSTR;
            if_id_valid    <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            if_id_pc       <= pc_nx;
            if_id_pc_plus4 <= pc_plus4_nx;
            if_id_instr    <= instr_nx;
            if_id_valid    <= valid_nx;
        end
    end

endmodule
